// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - tap-read sequencer between host, coefficient register file and MAC
// Optional abort input enabled by defining FIR_SEQ_ABORT_EN.
module fir_tap_sequencer #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic                     clk2,
    input  logic                     rst,
    input  logic                     cfg_wen,
    input  logic [ADDR_W-1:0]        cfg_waddr,
    input  logic signed [WIDTH-1:0]  cfg_wdata,
    output logic                     cfg_wready,
    input  logic [ADDR_W:0]          num_taps,
    input  logic                     start,
`ifdef FIR_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     busy,
    output logic                     done,
    output logic                     rf_wen,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic signed [WIDTH-1:0]  rf_din,
    output logic                     rf_ren,
    output logic [ADDR_W-1:0]        rf_raddr,
    input  logic signed [WIDTH-1:0]  rf_dout,
    output logic                     mac_clr,
    output logic                     mac_en,
    output logic signed [WIDTH-1:0]  mac_coef,
    output logic [ADDR_W-1:0]        mac_tap_idx,
    output logic                     mac_last
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] L_ONE   = (ADDR_W+1)'(1);

    state_t              r_state;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_rf_ren;
    logic                r_done;
    logic                r_mac_clr;
    logic                r_mac_en;
    logic                r_mac_last;
    logic [ADDR_W-1:0]   r_mac_tap_idx;

    logic [ADDR_W:0]     w_n_clamped;
    logic                w_last_addr;
    logic                w_abort;

`ifdef FIR_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_n_clamped = (num_taps > L_DEPTH) ? L_DEPTH : num_taps;
    assign w_last_addr = ({1'b0, r_cnt} == (r_n - L_ONE));

    // Host writes only win while idle, so a run never sees a half-updated table.
    assign cfg_wready = (r_state == S_IDLE);
    assign rf_wen     = cfg_wen & cfg_wready;
    assign rf_waddr   = cfg_waddr;
    assign rf_din     = cfg_wdata;

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign rf_ren      = r_rf_ren;
    assign rf_raddr    = r_cnt;
    assign mac_clr     = r_mac_clr;
    assign mac_en      = r_mac_en;
    assign mac_coef    = rf_dout;
    assign mac_tap_idx = r_mac_tap_idx;
    assign mac_last    = r_mac_last;

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_n           <= '0;
            r_cnt         <= '0;
            r_rf_ren      <= 1'b0;
            r_done        <= 1'b0;
            r_mac_clr     <= 1'b0;
            r_mac_en      <= 1'b0;
            r_mac_last    <= 1'b0;
            r_mac_tap_idx <= '0;
        end else begin
            r_mac_clr     <= 1'b0;
            r_done        <= 1'b0;
            // One stage of delay matches the register file's read latency.
            r_mac_en      <= r_rf_ren;
            r_mac_tap_idx <= r_cnt;
            r_mac_last    <= r_rf_ren & w_last_addr;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n <= w_n_clamped;
                        if (w_n_clamped == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_READ;
                            r_rf_ren  <= 1'b1;
                            r_cnt     <= '0;
                            r_mac_clr <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_last_addr) begin
                        r_rf_ren <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_abort && ((r_state == S_READ) || (r_state == S_DRAIN))) begin
                r_state    <= S_IDLE;
                r_rf_ren   <= 1'b0;
                r_cnt      <= '0;
                r_mac_en   <= 1'b0;
                r_mac_last <= 1'b0;
                r_done     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - scoreboard bench for fir_tap_sequencer with a register-file model
module tb_fir_tap_sequencer;

    logic               clk2 = 1'b0;
    logic               rst  = 1'b1;
    logic               cfg_wen = 1'b0;
    logic [5:0]         cfg_waddr = '0;
    logic [15:0]        cfg_wdata = '0;
    logic               cfg_wready;
    logic [6:0]         num_taps = '0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               busy, done, rf_wen, rf_ren, mac_clr, mac_en, mac_last;
    logic [5:0]         rf_waddr, rf_raddr, mac_tap_idx;
    logic [15:0]        rf_din, mac_coef;
    logic [15:0]        rf_dout = '0;

    always #5 clk2 = ~clk2;

    fir_tap_sequencer dut (
        .clk2(clk2), .rst(rst),
        .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata), .cfg_wready(cfg_wready),
        .num_taps(num_taps), .start(start),
`ifdef FIR_SEQ_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_din(rf_din),
        .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_dout(rf_dout),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_coef(mac_coef),
        .mac_tap_idx(mac_tap_idx), .mac_last(mac_last)
    );

    logic [15:0] rf_mem [0:63];
    logic [15:0] model  [0:63];

    always @(posedge clk2) begin
        if (rf_wen) rf_mem[rf_waddr] <= rf_din;
        if (rf_ren) rf_dout <= rf_mem[rf_raddr];
    end

    typedef struct {
        int          cyc;
        logic [15:0] coef;
        logic [5:0]  idx;
        logic        last;
    } beat_t;

    beat_t beat_q[$];
    int    clr_q[$];
    int    done_q[$];
    beat_t mb;
    int    mc;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rd_total = 0;

    always @(posedge clk2) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk2) begin
        if (rf_ren) rd_total = rd_total + 1;
        if (mac_en) begin
            if (beat_q.size() == 0) begin
                chk("unexpected_mac_en", mac_en, 0);
            end else begin
                mb = beat_q.pop_front();
                chk("beat_cycle", cyc, mb.cyc);
                chk("mac_coef", mac_coef, mb.coef);
                chk("mac_tap_idx", mac_tap_idx, mb.idx);
                chk("mac_last", mac_last, mb.last);
            end
        end else if (mac_last) begin
            chk("mac_last_without_en", mac_last, 0);
        end
        if (mac_clr) begin
            if (clr_q.size() == 0) chk("unexpected_mac_clr", mac_clr, 0);
            else begin
                mc = clr_q.pop_front();
                chk("mac_clr_cycle", cyc, mc);
            end
        end
        if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", done, 0);
            else begin
                mc = done_q.pop_front();
                chk("done_cycle", cyc, mc);
            end
        end
    end

    task automatic tick;
        @(posedge clk2);
        #1;
    endtask

    task automatic start_run(input int n, input int max_beats, input bit exp_done);
        int    k;
        int    nn;
        beat_t nb;
        k  = cyc;
        nn = (n > 64) ? 64 : n;
        num_taps = 7'(n);
        start    = 1'b1;
        if (nn > 0) clr_q.push_back(k + 1);
        for (int i = 0; i < nn && i < max_beats; i++) begin
            nb.cyc  = k + 2 + i;
            nb.coef = model[i];
            nb.idx  = 6'(i);
            nb.last = (i == nn - 1);
            beat_q.push_back(nb);
        end
        if (exp_done) done_q.push_back((nn == 0) ? k + 1 : k + nn + 2);
        tick;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 300) begin
            tick;
            t++;
        end
        chk(name, busy, 0);
    endtask

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        cfg_waddr = a;
        cfg_wdata = d;
        cfg_wen   = 1'b1;
        #1;
        chk("wr_idle_rf_wen", rf_wen, 1);
        tick;
        cfg_wen  = 1'b0;
        model[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int k;
        int r0;
        int t;
        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rf_ren", rf_ren, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_mac_last", mac_last, 0);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_cfg_wready", cfg_wready, 1);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 64; i++) host_write(6'(i), 16'(i - 32));
        r0 = rd_total;
        start_run(64, 64, 1);
        chk("run64_busy", busy, 1);
        chk("run64_wready", cfg_wready, 0);
        wait_idle("run64_idle");
        chk("run64_reads", rd_total - r0, 64);

        k = cyc;
        start_run(64, 8, 0);
        while (cyc < k + 10) tick;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rf_ren", rf_ren, 0);
        chk("midrst_mac_en", mac_en, 0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        r0 = rd_total;
        start_run(64, 64, 1);
        wait_idle("after_rst_idle");
        chk("after_rst_reads", rd_total - r0, 64);

        r0 = rd_total;
        start_run(0, 0, 1);
        chk("n0_busy_one", busy, 1);
        tick;
        chk("n0_busy_clear", busy, 0);
        chk("n0_reads", rd_total - r0, 0);

        r0 = rd_total;
        start_run(100, 64, 1);
        wait_idle("n100_idle");
        tick;
        chk("n100_reads", rd_total - r0, 64);

        k = cyc;
        start_run(8, 8, 1);
        tick;
        tick;
        cfg_waddr = 6'd5;
        cfg_wdata = 16'h7FFF;
        cfg_wen   = 1'b1;
        #1;
        chk("hold_wready_low", cfg_wready, 0);
        chk("hold_rf_wen_low", rf_wen, 0);
        t = 0;
        while (!cfg_wready && t < 100) begin
            tick;
            t++;
        end
        chk("hold_accept_cycle", cyc, k + 11);
        chk("hold_rf_wen", rf_wen, 1);
        chk("hold_rf_waddr", rf_waddr, 5);
        tick;
        cfg_wen  = 1'b0;
        model[5] = 16'h7FFF;

        model[0]  = 16'h8000;
        cfg_waddr = 6'd0;
        cfg_wdata = 16'h8000;
        cfg_wen   = 1'b1;
        start_run(6, 6, 1);
        cfg_wen = 1'b0;
        wait_idle("samecyc_idle");

        k = cyc;
        start_run(4, 4, 1);
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (cyc < k + 6) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("ignored_start_busy", busy, 0);
        repeat (5) tick;

`ifdef FIR_SEQ_ABORT_EN
        k = cyc;
        start_run(10, 3, 0);
        while (cyc < k + 4) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rf_ren", rf_ren, 0);
        repeat (3) tick;
`endif

        repeat (4) tick;
        chk("beat_q_empty", beat_q.size(), 0);
        chk("clr_q_empty", clr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
